tx_arp_reply: RTL and testbench

- Downstream neighbour of the ARP receive parser.
- Consumes its one-cycle reply trigger plus the requester MAC/IP, and serialises a complete 60-byte Ethernet ARP reply onto the 8-bit AXI-Stream TX path toward the RGMII MAC.
- The frame carries no preamble and no FCS; the MAC appends both.

---
 rtl/eth_pkg.sv | 43 ++++
 rtl/arp_frame_byte_mux.sv | 55 +++++
 rtl/tx_arp_reply.sv | 150 +++++++++++++++
 tb/tb_tx_arp_reply.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_pkg.sv
// Shared Ethernet/ARP constants and helpers used by the RX parser and the TX reply path.
package eth_pkg;

    localparam logic [15:0] ARP_TYPE      = 16'h0806;
    localparam logic [15:0] ARP_HTYPE     = 16'h0001;
    localparam logic [15:0] IPV4_TYPE     = 16'h0800;
    localparam logic [7:0]  ARP_HLEN      = 8'h06;
    localparam logic [7:0]  ARP_PLEN      = 8'h04;
    localparam logic [15:0] ARP_REQUEST   = 16'h0001;
    localparam logic [15:0] ARP_REPLY     = 16'h0002;
    localparam int          ETH_MIN_FRAME = 60;
    localparam logic [5:0]  ARP_LAST_IDX  = 6'd59;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } tx_state_e;

    // Byte i of a 48-bit field, most significant byte first.
    function automatic logic [7:0] get_byte48(input logic [47:0] v, input logic [2:0] i);
        case (i)
            3'd0:    get_byte48 = v[47:40];
            3'd1:    get_byte48 = v[39:32];
            3'd2:    get_byte48 = v[31:24];
            3'd3:    get_byte48 = v[23:16];
            3'd4:    get_byte48 = v[15:8];
            3'd5:    get_byte48 = v[7:0];
            default: get_byte48 = 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] get_byte32(input logic [31:0] v, input logic [1:0] i);
        case (i)
            2'd0:    get_byte32 = v[31:24];
            2'd1:    get_byte32 = v[23:16];
            2'd2:    get_byte32 = v[15:8];
            2'd3:    get_byte32 = v[7:0];
            default: get_byte32 = 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/arp_frame_byte_mux.sv
// Combinational map from frame byte index to the byte value of a 60-byte ARP reply.
module arp_frame_byte_mux
    import eth_pkg::*;
(
    input  logic [5:0]  byte_cnt_i,
    input  logic [47:0] fpga_mac_i,
    input  logic [31:0] fpga_ip_i,
    input  logic [47:0] peer_mac_i,
    input  logic [31:0] peer_ip_i,
    output logic [7:0]  byte_o
);

    logic [5:0] rel_s;

    // Select the field covering byte_cnt_i, then the byte within it.
    always_comb begin
        byte_o = 8'h00;
        rel_s  = 6'd0;
        if (byte_cnt_i <= 6'd5) begin
            byte_o = get_byte48(peer_mac_i, byte_cnt_i[2:0]);
        end else if (byte_cnt_i <= 6'd11) begin
            rel_s  = byte_cnt_i - 6'd6;
            byte_o = get_byte48(fpga_mac_i, rel_s[2:0]);
        end else if (byte_cnt_i <= 6'd21) begin
            case (byte_cnt_i)
                6'd12:   byte_o = ARP_TYPE[15:8];
                6'd13:   byte_o = ARP_TYPE[7:0];
                6'd14:   byte_o = ARP_HTYPE[15:8];
                6'd15:   byte_o = ARP_HTYPE[7:0];
                6'd16:   byte_o = IPV4_TYPE[15:8];
                6'd17:   byte_o = IPV4_TYPE[7:0];
                6'd18:   byte_o = ARP_HLEN;
                6'd19:   byte_o = ARP_PLEN;
                6'd20:   byte_o = ARP_REPLY[15:8];
                6'd21:   byte_o = ARP_REPLY[7:0];
                default: byte_o = 8'h00;
            endcase
        end else if (byte_cnt_i <= 6'd27) begin
            rel_s  = byte_cnt_i - 6'd22;
            byte_o = get_byte48(fpga_mac_i, rel_s[2:0]);
        end else if (byte_cnt_i <= 6'd31) begin
            rel_s  = byte_cnt_i - 6'd28;
            byte_o = get_byte32(fpga_ip_i, rel_s[1:0]);
        end else if (byte_cnt_i <= 6'd37) begin
            rel_s  = byte_cnt_i - 6'd32;
            byte_o = get_byte48(peer_mac_i, rel_s[2:0]);
        end else if (byte_cnt_i <= 6'd41) begin
            rel_s  = byte_cnt_i - 6'd38;
            byte_o = get_byte32(peer_ip_i, rel_s[1:0]);
        end else begin
            byte_o = 8'h00;
        end
    end

endmodule

// File: rtl/tx_arp_reply.sv
// Serialises a 60-byte ARP reply onto an 8-bit AXI-Stream, with an inter-frame gap
// and a single newest-wins pending request slot.
module tx_arp_reply
    import eth_pkg::*;
#(
    parameter logic [47:0] FPGA_MAC   = 48'h00_0A_35_01_FE_C0,
    parameter logic [31:0] FPGA_IP    = 32'hC0A8_006E,
    parameter int          IFG_CYCLES = 12
) (
    input  logic        CLK_125M,
    input  logic        SYS_RST_N,
    input  logic        TRIG_TX_ARP,
    input  logic [47:0] PC_MAC,
    input  logic [31:0] PC_IP,
    output logic [7:0]  RGMII_TX_DATA,
    output logic        RGMII_TX_VALID,
    output logic        RGMII_TX_LAST,
    input  logic        RGMII_TX_READY,
    output logic        TX_ARP_BUSY,
    output logic        TX_ARP_DONE
);

    // GAP always lasts at least one clock, so IFG_CYCLES=0 behaves like 1.
    localparam logic [7:0] GAP_LAST = (IFG_CYCLES == 0) ? 8'd0 : 8'(IFG_CYCLES - 1);

    tx_state_e   state_q, state_d;
    logic [5:0]  byte_cnt_q, byte_cnt_d;
    logic [7:0]  gap_cnt_q, gap_cnt_d;
    logic [47:0] mac_q, mac_d, pend_mac_q, pend_mac_d;
    logic [31:0] ip_q, ip_d, pend_ip_q, pend_ip_d;
    logic        pend_q, pend_d;
    logic        valid_s, hs_s, last_s;
    logic [7:0]  byte_s;

    assign valid_s = (state_q == ST_SEND);
    assign hs_s    = valid_s && RGMII_TX_READY;
    assign last_s  = valid_s && (byte_cnt_q == ARP_LAST_IDX);

    arp_frame_byte_mux u_mux (
        .byte_cnt_i (byte_cnt_q),
        .fpga_mac_i (FPGA_MAC),
        .fpga_ip_i  (FPGA_IP),
        .peer_mac_i (mac_q),
        .peer_ip_i  (ip_q),
        .byte_o     (byte_s)
    );

    // Next-state logic: frame sequencing, gap timing and pending-request capture.
    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        mac_d      = mac_q;
        ip_d       = ip_q;
        pend_d     = pend_q;
        pend_mac_d = pend_mac_q;
        pend_ip_d  = pend_ip_q;
        case (state_q)
            ST_IDLE: begin
                if (TRIG_TX_ARP) begin
                    mac_d      = PC_MAC;
                    ip_d       = PC_IP;
                    byte_cnt_d = 6'd0;
                    state_d    = ST_SEND;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (TRIG_TX_ARP) begin
                    pend_d     = 1'b1;
                    pend_mac_d = PC_MAC;
                    pend_ip_d  = PC_IP;
                end else begin
                    pend_d = pend_q;
                end
                if (hs_s && last_s) begin
                    gap_cnt_d = 8'd0;
                    state_d   = ST_GAP;
                end else if (hs_s) begin
                    byte_cnt_d = byte_cnt_q + 6'd1;
                end else begin
                    state_d = ST_SEND;
                end
            end
            ST_GAP: begin
                // A trigger landing on the exit cycle is newer than any pending one.
                if (gap_cnt_q == GAP_LAST) begin
                    if (TRIG_TX_ARP) begin
                        mac_d      = PC_MAC;
                        ip_d       = PC_IP;
                        pend_d     = 1'b0;
                        byte_cnt_d = 6'd0;
                        state_d    = ST_SEND;
                    end else if (pend_q) begin
                        mac_d      = pend_mac_q;
                        ip_d       = pend_ip_q;
                        pend_d     = 1'b0;
                        byte_cnt_d = 6'd0;
                        state_d    = ST_SEND;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    gap_cnt_d = gap_cnt_q + 8'd1;
                    if (TRIG_TX_ARP) begin
                        pend_d     = 1'b1;
                        pend_mac_d = PC_MAC;
                        pend_ip_d  = PC_IP;
                    end else begin
                        pend_d = pend_q;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge CLK_125M) begin
        if (!SYS_RST_N) begin
            state_q    <= ST_IDLE;
            byte_cnt_q <= 6'd0;
            gap_cnt_q  <= 8'd0;
            mac_q      <= 48'd0;
            ip_q       <= 32'd0;
            pend_q     <= 1'b0;
            pend_mac_q <= 48'd0;
            pend_ip_q  <= 32'd0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            mac_q      <= mac_d;
            ip_q       <= ip_d;
            pend_q     <= pend_d;
            pend_mac_q <= pend_mac_d;
            pend_ip_q  <= pend_ip_d;
        end
    end

    assign RGMII_TX_VALID = valid_s;
    assign RGMII_TX_DATA  = valid_s ? byte_s : 8'h00;
    assign RGMII_TX_LAST  = last_s;
    assign TX_ARP_BUSY    = (state_q != ST_IDLE);
    assign TX_ARP_DONE    = hs_s && last_s;

endmodule

// File: tb/tb_tx_arp_reply.sv
// Directed self-checking bench for tx_arp_reply (IFG 12 instance and an IFG 0 instance).
module tb_tx_arp_reply;

    localparam logic [47:0] TB_FPGA_MAC = 48'h000A3501FEC0;
    localparam logic [31:0] TB_FPGA_IP  = 32'hC0A8006E;
    localparam logic [47:0] MAC_A = 48'h1C1B0DAABBCC;
    localparam logic [31:0] IP_A  = 32'hC0A80064;
    localparam logic [47:0] MAC_B = 48'h021122334455;
    localparam logic [31:0] IP_B  = 32'h0A000001;
    localparam logic [47:0] MAC_C = 48'hA0B0C0D0E0F0;
    localparam logic [31:0] IP_C  = 32'hAC100203;

    logic        clk, rst_n, trig, ready, sel;
    logic [47:0] pc_mac;
    logic [31:0] pc_ip;
    logic [7:0]  d12_data, d0_data, data;
    logic        d12_valid, d12_last, d12_busy, d12_done;
    logic        d0_valid, d0_last, d0_busy, d0_done;
    logic        valid, last, busy, done;
    int          n_total, n_bad;

    tx_arp_reply #(.IFG_CYCLES(12)) dut (
        .CLK_125M(clk), .SYS_RST_N(rst_n), .TRIG_TX_ARP(trig & ~sel),
        .PC_MAC(pc_mac), .PC_IP(pc_ip),
        .RGMII_TX_DATA(d12_data), .RGMII_TX_VALID(d12_valid), .RGMII_TX_LAST(d12_last),
        .RGMII_TX_READY(ready), .TX_ARP_BUSY(d12_busy), .TX_ARP_DONE(d12_done)
    );

    tx_arp_reply #(.IFG_CYCLES(0)) dut0 (
        .CLK_125M(clk), .SYS_RST_N(rst_n), .TRIG_TX_ARP(trig & sel),
        .PC_MAC(pc_mac), .PC_IP(pc_ip),
        .RGMII_TX_DATA(d0_data), .RGMII_TX_VALID(d0_valid), .RGMII_TX_LAST(d0_last),
        .RGMII_TX_READY(ready), .TX_ARP_BUSY(d0_busy), .TX_ARP_DONE(d0_done)
    );

    assign data  = sel ? d0_data  : d12_data;
    assign valid = sel ? d0_valid : d12_valid;
    assign last  = sel ? d0_last  : d12_last;
    assign busy  = sel ? d0_busy  : d12_busy;
    assign done  = sel ? d0_done  : d12_done;

    initial clk = 1'b0;
    always #4 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_byte(input logic [47:0] mac, input logic [31:0] ip, input int i);
        if (i < 6)       return 8'(mac >> (8 * (5 - i)));
        else if (i < 12) return 8'(TB_FPGA_MAC >> (8 * (11 - i)));
        else if (i < 22) begin
            case (i)
                12: return 8'h08;  13: return 8'h06;
                14: return 8'h00;  15: return 8'h01;
                16: return 8'h08;  17: return 8'h00;
                18: return 8'h06;  19: return 8'h04;
                20: return 8'h00;  21: return 8'h02;
                default: return 8'hxx;
            endcase
        end
        else if (i < 28) return 8'(TB_FPGA_MAC >> (8 * (27 - i)));
        else if (i < 32) return 8'(TB_FPGA_IP >> (8 * (31 - i)));
        else if (i < 38) return 8'(mac >> (8 * (37 - i)));
        else if (i < 42) return 8'(ip >> (8 * (41 - i)));
        else             return 8'h00;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pulse the trigger for one edge and check the first byte is valid right after.
    task automatic send_trig(input logic [47:0] mac, input logic [31:0] ip, input string tag);
        trig = 1'b1; pc_mac = mac; pc_ip = ip;
        step();
        trig = 1'b0;
        #1;
        chk({tag, "_first_valid"}, valid, 1'b1);
        chk({tag, "_first_busy"}, busy, 1'b1);
    endtask

    task automatic recv_frame(input logic [47:0] mac, input logic [31:0] ip, input bit rnd,
                              input int inj1, input logic [47:0] m1, input logic [31:0] i1,
                              input int inj2, input logic [47:0] m2, input logic [31:0] i2,
                              input string tag);
        int idx = 0;
        int cyc = 0;
        bit stall = 1'b0;
        bit did1 = 1'b0;
        bit did2 = 1'b0;
        logic [7:0] pd = 8'h00;
        logic pl = 1'b0;
        while (idx < 60 && cyc < 4000) begin
            ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (idx == inj1 && !did1) begin trig = 1'b1; pc_mac = m1; pc_ip = i1; did1 = 1'b1; end
            if (idx == inj2 && !did2) begin trig = 1'b1; pc_mac = m2; pc_ip = i2; did2 = 1'b1; end
            #1;
            chk({tag, "_valid"}, valid, 1'b1);
            if (stall) begin
                chk({tag, "_stall_data"}, data, pd);
                chk({tag, "_stall_last"}, last, pl);
            end
            if (valid && ready) begin
                chk($sformatf("%s_byte%0d", tag, idx), data, exp_byte(mac, ip, idx));
                chk($sformatf("%s_last%0d", tag, idx), last, idx == 59);
                chk($sformatf("%s_done%0d", tag, idx), done, idx == 59);
                idx++;
            end else begin
                chk({tag, "_done_stalled"}, done, 1'b0);
            end
            stall = valid && !ready;
            pd = data;
            pl = last;
            step();
            trig = 1'b0;
            cyc++;
        end
        ready = 1'b1;
        chk({tag, "_bytes_received"}, idx, 60);
    endtask

    // Gap of 12 clocks with no pending work: BUSY holds 12 cycles then drops.
    task automatic gap_idle12(input string tag);
        chk({tag, "_gap_valid"}, valid, 1'b0);
        chk({tag, "_gap_busy"}, busy, 1'b1);
        repeat (11) step();
        chk({tag, "_gap_busy_end"}, busy, 1'b1);
        step();
        chk({tag, "_idle_busy"}, busy, 1'b0);
    endtask

    task automatic quiet(input int n, input string tag);
        int vcnt = 0;
        repeat (n) begin
            if (valid) vcnt++;
            step();
        end
        chk({tag, "_no_extra_frame"}, vcnt, 0);
    endtask

    initial begin
        int n;
        n_total = 0; n_bad = 0;
        rst_n = 1'b0; trig = 1'b0; ready = 1'b1; sel = 1'b0;
        pc_mac = 48'd0; pc_ip = 32'd0;
        repeat (3) step();
        chk("rst_valid", {d12_valid, d0_valid}, 2'b00);
        chk("rst_last", {d12_last, d0_last}, 2'b00);
        chk("rst_busy", {d12_busy, d0_busy}, 2'b00);
        chk("rst_done", {d12_done, d0_done}, 2'b00);
        chk("rst_data", {d12_data, d0_data}, 16'h0000);
        rst_n = 1'b1;
        step();

        // 1: READY tied high
        send_trig(MAC_A, IP_A, "t1");
        recv_frame(MAC_A, IP_A, 1'b0, -1, 48'd0, 32'd0, -1, 48'd0, 32'd0, "t1");
        gap_idle12("t1");

        // 2: random READY
        send_trig(MAC_A, IP_A, "t2");
        recv_frame(MAC_A, IP_A, 1'b1, -1, 48'd0, 32'd0, -1, 48'd0, 32'd0, "t2");
        gap_idle12("t2");

        // 3: B at byte 20, C at byte 40; only C follows
        send_trig(MAC_A, IP_A, "t3");
        recv_frame(MAC_A, IP_A, 1'b0, 20, MAC_B, IP_B, 40, MAC_C, IP_C, "t3a");
        n = 0;
        while (!valid && n < 100) begin n++; step(); end
        chk("t3_gap_len", n, 12);
        recv_frame(MAC_C, IP_C, 1'b0, -1, 48'd0, 32'd0, -1, 48'd0, 32'd0, "t3c");
        gap_idle12("t3c");
        quiet(30, "t3");

        // 4: reset at byte 30
        send_trig(MAC_B, IP_B, "t4");
        repeat (30) step();
        chk("t4_byte30", data, exp_byte(MAC_B, IP_B, 30));
        rst_n = 1'b0;
        step();
        chk("t4_rst_valid", valid, 1'b0);
        chk("t4_rst_last", last, 1'b0);
        chk("t4_rst_busy", busy, 1'b0);
        rst_n = 1'b1;
        step();
        quiet(5, "t4_after_rst");
        send_trig(MAC_C, IP_C, "t4b");
        recv_frame(MAC_C, IP_C, 1'b0, -1, 48'd0, 32'd0, -1, 48'd0, 32'd0, "t4b");
        gap_idle12("t4b");

        // 5a: trigger on the last GAP cycle, IFG 12
        send_trig(MAC_A, IP_A, "t5a");
        recv_frame(MAC_A, IP_A, 1'b0, -1, 48'd0, 32'd0, -1, 48'd0, 32'd0, "t5a");
        repeat (11) step();
        chk("t5a_busy_exit", busy, 1'b1);
        send_trig(MAC_B, IP_B, "t5a_exit");
        recv_frame(MAC_B, IP_B, 1'b0, -1, 48'd0, 32'd0, -1, 48'd0, 32'd0, "t5a_b");
        gap_idle12("t5a_b");
        quiet(20, "t5a");

        // 5b: IFG 0 instance, trigger on its single GAP cycle
        sel = 1'b1;
        #1;
        chk("t5b_idle_busy", busy, 1'b0);
        send_trig(MAC_C, IP_C, "t5b");
        recv_frame(MAC_C, IP_C, 1'b0, -1, 48'd0, 32'd0, -1, 48'd0, 32'd0, "t5b");
        chk("t5b_gap_valid", valid, 1'b0);
        chk("t5b_gap_busy", busy, 1'b1);
        send_trig(MAC_A, IP_A, "t5b_exit");
        recv_frame(MAC_A, IP_A, 1'b0, -1, 48'd0, 32'd0, -1, 48'd0, 32'd0, "t5b_a");
        chk("t5b_gap_busy2", busy, 1'b1);
        step();
        chk("t5b_idle", busy, 1'b0);
        quiet(20, "t5b");
        sel = 1'b0;

        // 6: READY low for 1000 clocks
        ready = 1'b0;
        #1;
        send_trig(MAC_B, IP_B, "t6");
        repeat (1000) begin
            chk("t6_hold_valid", valid, 1'b1);
            chk("t6_hold_data", data, exp_byte(MAC_B, IP_B, 0));
            chk("t6_hold_done", done, 1'b0);
            step();
        end
        recv_frame(MAC_B, IP_B, 1'b0, -1, 48'd0, 32'd0, -1, 48'd0, 32'd0, "t6");
        gap_idle12("t6");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
